// File: rtl/code_lock_pkg.sv
// Shared types and constants for the combination-lock controller.
package code_lock_pkg;

    typedef enum logic [2:0] {
        ENTRY,
        CHECK,
        OPEN,
        FAIL,
        LOCKOUT,
        PROGRAM
    } state_t;

    localparam int PB_SHORT = 0;
    localparam int PB_LONG  = 1;
    localparam int PB_VLONG = 2;

    localparam int TMR_W = 15;

endpackage

// File: rtl/code_lock_ctrl_lock_timer.sv
// Loadable down-counter shared by the FAIL and LOCKOUT holds.
// o_done pulses for the single cycle in which the running count sits at zero.
module lock_timer
    import code_lock_pkg::*;
(
    input  logic             i_clk,
    input  logic             i_rstn,
    input  logic             i_load,
    input  logic [TMR_W-1:0] i_load_val,
    output logic             o_done
);

    logic [TMR_W-1:0] r_cnt;
    logic             r_run;

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            r_cnt <= '0;
            r_run <= 1'b0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
            r_run <= 1'b1;
        end else if (r_run) begin
            if (r_cnt == '0)
                r_run <= 1'b0;
            else
                r_cnt <= r_cnt - 1'b1;
        end
    end

    assign o_done = r_run && (r_cnt == '0);

endmodule

// File: rtl/code_lock_ctrl.sv
// Combination-lock controller: collects DIGITS nibbles, checks them, and holds error/lockout.
// Define CODE_LOCK_PROGRAM_EN to allow reprogramming the stored code from OPEN.
module code_lock_ctrl
    import code_lock_pkg::*;
#(
    parameter int          DIGITS         = 4,
    parameter logic [15:0] CODE           = 16'h1234,
    parameter int          FAIL_CYCLES    = 10000,
    parameter int          MAX_TRIES      = 3,
    parameter int          LOCKOUT_CYCLES = 30000
) (
    input  logic       i_clk,
    input  logic       i_rstn,
    input  logic [3:0] i_enc,
    input  logic [2:0] i_pb_press_type,
    output logic [3:0] o_display_value,
    output logic [1:0] o_display_select,
    output logic       o_unlocked,
    output logic       o_error,
    output logic       o_locked_out,
    output logic [1:0] o_fail_cnt
);

    localparam int               BW       = DIGITS * 4;
    localparam logic [1:0]       LAST_IDX = 2'(DIGITS - 1);
    localparam logic [1:0]       MAX_T    = 2'(MAX_TRIES);
    localparam logic [TMR_W-1:0] FAIL_LD  = TMR_W'(FAIL_CYCLES - 1);
    localparam logic [TMR_W-1:0] LOCK_LD  = TMR_W'(LOCKOUT_CYCLES - 1);

    state_t           r_state;
    logic [1:0]       r_idx;
    logic [BW-1:0]    r_buf;
    logic [BW-1:0]    w_buf_wr;
    logic [BW-1:0]    w_code;
    logic             w_match;
    logic             w_short;
    logic             w_long;
    logic             w_ld_fail;
    logic             w_ld_lock;
    logic             w_tmr_load;
    logic [TMR_W-1:0] w_tmr_val;
    logic             w_tmr_done;

    // Only the highest-priority press bit acts.
    assign w_long  = i_pb_press_type[PB_LONG] & ~i_pb_press_type[PB_VLONG];
    assign w_short = i_pb_press_type[PB_SHORT] & ~i_pb_press_type[PB_LONG]
                   & ~i_pb_press_type[PB_VLONG];

    // Buffer with the current slot overwritten; digit 0 lives in the MS nibble.
    always_comb begin
        w_buf_wr = r_buf;
        w_buf_wr[(DIGITS - 1 - int'(r_idx)) * 4 +: 4] = i_enc;
    end

`ifdef CODE_LOCK_PROGRAM_EN
    logic          w_vlong;
    logic [BW-1:0] r_code;

    assign w_vlong = i_pb_press_type[PB_VLONG];

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn)
            r_code <= CODE[BW-1:0];
        else if (r_state == PROGRAM && w_short && r_idx == LAST_IDX)
            r_code <= w_buf_wr;
    end

    assign w_code = r_code;
`else
    assign w_code = CODE[BW-1:0];
`endif

    assign w_match = (r_buf == w_code);

    // Timer must load on the same edge the FSM enters FAIL/LOCKOUT.
    assign w_ld_fail  = (r_state == CHECK) && !w_match;
    assign w_ld_lock  = (r_state == FAIL) && w_tmr_done && (r_fail_cnt_eq_max());
    assign w_tmr_load = w_ld_fail || w_ld_lock;
    assign w_tmr_val  = w_ld_lock ? LOCK_LD : FAIL_LD;

    function automatic logic r_fail_cnt_eq_max();
        return o_fail_cnt == MAX_T;
    endfunction

    lock_timer u_timer (
        .i_clk      (i_clk),
        .i_rstn     (i_rstn),
        .i_load     (w_tmr_load),
        .i_load_val (w_tmr_val),
        .o_done     (w_tmr_done)
    );

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            r_state          <= ENTRY;
            r_idx            <= 2'd0;
            r_buf            <= '0;
            o_display_value  <= 4'd0;
            o_display_select <= 2'd0;
            o_unlocked       <= 1'b0;
            o_error          <= 1'b0;
            o_locked_out     <= 1'b0;
            o_fail_cnt       <= 2'd0;
        end else begin
            o_display_value  <= 4'd0;
            o_display_select <= 2'd0;
            case (r_state)
                ENTRY: begin
                    o_display_value <= i_enc;
                    if (w_long) begin
                        r_buf <= '0;
                        r_idx <= 2'd0;
                    end else if (w_short) begin
                        r_buf <= w_buf_wr;
                        if (r_idx == LAST_IDX) begin
                            r_idx           <= 2'd0;
                            r_state         <= CHECK;
                            o_display_value <= 4'd0;
                        end else begin
                            r_idx            <= r_idx + 2'd1;
                            o_display_select <= r_idx + 2'd1;
                        end
                    end else begin
                        o_display_select <= r_idx;
                    end
                end
                CHECK: begin
                    r_buf <= '0;
                    if (w_match) begin
                        r_state    <= OPEN;
                        o_unlocked <= 1'b1;
                        o_fail_cnt <= 2'd0;
                    end else begin
                        r_state    <= FAIL;
                        o_error    <= 1'b1;
                        o_fail_cnt <= (o_fail_cnt == MAX_T) ? o_fail_cnt : o_fail_cnt + 2'd1;
                    end
                end
                OPEN: begin
                    if (w_long) begin
                        r_state         <= ENTRY;
                        o_unlocked      <= 1'b0;
                        r_buf           <= '0;
                        r_idx           <= 2'd0;
                        o_display_value <= i_enc;
                    end
`ifdef CODE_LOCK_PROGRAM_EN
                    else if (w_vlong) begin
                        r_state         <= PROGRAM;
                        o_unlocked      <= 1'b0;
                        r_buf           <= '0;
                        r_idx           <= 2'd0;
                        o_display_value <= i_enc;
                    end
`endif
                end
                FAIL: begin
                    if (w_tmr_done) begin
                        o_error <= 1'b0;
                        if (o_fail_cnt == MAX_T) begin
                            r_state      <= LOCKOUT;
                            o_locked_out <= 1'b1;
                        end else begin
                            r_state         <= ENTRY;
                            r_buf           <= '0;
                            r_idx           <= 2'd0;
                            o_display_value <= i_enc;
                        end
                    end
                end
                LOCKOUT: begin
                    if (w_tmr_done) begin
                        r_state         <= ENTRY;
                        o_locked_out    <= 1'b0;
                        o_fail_cnt      <= 2'd0;
                        r_buf           <= '0;
                        r_idx           <= 2'd0;
                        o_display_value <= i_enc;
                    end
                end
`ifdef CODE_LOCK_PROGRAM_EN
                PROGRAM: begin
                    o_display_value <= i_enc;
                    if (w_long) begin
                        r_state         <= OPEN;
                        o_unlocked      <= 1'b1;
                        r_buf           <= '0;
                        r_idx           <= 2'd0;
                        o_display_value <= 4'd0;
                    end else if (w_short) begin
                        if (r_idx == LAST_IDX) begin
                            r_state         <= OPEN;
                            o_unlocked      <= 1'b1;
                            r_buf           <= '0;
                            r_idx           <= 2'd0;
                            o_display_value <= 4'd0;
                        end else begin
                            r_buf            <= w_buf_wr;
                            r_idx            <= r_idx + 2'd1;
                            o_display_select <= r_idx + 2'd1;
                        end
                    end else begin
                        o_display_select <= r_idx;
                    end
                end
`endif
                default: r_state <= ENTRY;
            endcase
        end
    end

endmodule

// File: tb/tb_code_lock_ctrl.sv
// Directed bench for code_lock_ctrl: entry, priority, fail/lockout timing, async reset,
// and code programming when CODE_LOCK_PROGRAM_EN is defined.
module tb_code_lock_ctrl;

    logic       clk  = 1'b0;
    logic       rstn = 1'b0;
    logic [3:0] enc  = 4'd0;
    logic [2:0] pb   = 3'd0;
    logic [3:0] disp_val;
    logic [1:0] disp_sel;
    logic       unlocked;
    logic       err;
    logic       locked_out;
    logic [1:0] fail_cnt;

    int total = 0;
    int bad   = 0;
    int n;

    code_lock_ctrl dut (
        .i_clk            (clk),
        .i_rstn           (rstn),
        .i_enc            (enc),
        .i_pb_press_type  (pb),
        .o_display_value  (disp_val),
        .o_display_select (disp_sel),
        .o_unlocked       (unlocked),
        .o_error          (err),
        .o_locked_out     (locked_out),
        .o_fail_cnt       (fail_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // One-cycle press; returns at the negedge after the sampling edge.
    task automatic press(input logic [2:0] kind, input logic [3:0] val);
        @(negedge clk);
        enc = val;
        pb  = kind;
        @(negedge clk);
        pb  = 3'd0;
    endtask

    task automatic enter4(input logic [3:0] a, b, c, d);
        press(3'b001, a);
        press(3'b001, b);
        press(3'b001, c);
        press(3'b001, d);
    endtask

    // Counts cycles the error flag stays high, from the first high sample.
    task automatic count_err(output int cnt);
        cnt = 0;
        while (err && cnt < 20000) begin
            cnt++;
            @(negedge clk);
        end
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_unlocked", unlocked, 0);
        chk("rst_error", err, 0);
        chk("rst_lockout", locked_out, 0);
        chk("rst_fail_cnt", fail_cnt, 0);
        chk("rst_disp_val", disp_val, 0);
        chk("rst_disp_sel", disp_sel, 0);
        rstn = 1'b1;
        @(negedge clk);

        // correct code, select stepping
        press(3'b001, 4'd1);
        chk("sel_after_1", disp_sel, 1);
        chk("val_after_1", disp_val, 1);
        press(3'b001, 4'd2);
        chk("sel_after_2", disp_sel, 2);
        press(3'b001, 4'd3);
        chk("sel_after_3", disp_sel, 3);
        press(3'b001, 4'd4);
        chk("unl_in_check", unlocked, 0);
        @(negedge clk);
        chk("unl_two_cycles", unlocked, 1);
        chk("open_fail_cnt", fail_cnt, 0);
        chk("open_disp_val", disp_val, 0);
        press(3'b001, 4'd5);
        chk("open_short_ign", unlocked, 1);
`ifndef CODE_LOCK_PROGRAM_EN
        press(3'b100, 4'd0);
        chk("open_vlong_ign", unlocked, 1);
`endif
        press(3'b010, 4'd0);
        chk("relock", unlocked, 0);
        chk("relock_sel", disp_sel, 0);

        // priority: long beats short, very long ignored in ENTRY
        press(3'b001, 4'd1);
        press(3'b001, 4'd2);
        chk("prio_sel2", disp_sel, 2);
        press(3'b011, 4'd7);
        chk("prio_long_wins", disp_sel, 0);
        press(3'b001, 4'd1);
        press(3'b100, 4'd9);
        chk("entry_vlong_ign", disp_sel, 1);
        press(3'b010, 4'd0);
        enter4(4'd1, 4'd2, 4'd3, 4'd4);
        @(negedge clk);
        chk("prio_unlock", unlocked, 1);
        press(3'b010, 4'd0);

        // wrong codes -> lockout
        enter4(4'd1, 4'd2, 4'd3, 4'd5);
        chk("err_in_check", err, 0);
        @(negedge clk);
        chk("err_set", err, 1);
        chk("fail_cnt_1", fail_cnt, 1);
        count_err(n);
        chk("fail1_len", n, 10000);
        chk("fail1_no_lock", locked_out, 0);
        chk("fail1_sel", disp_sel, 0);
        press(3'b001, 4'd1);
        chk("fail1_idx_restart", disp_sel, 1);
        press(3'b001, 4'd2);
        press(3'b001, 4'd3);
        press(3'b001, 4'd5);
        @(negedge clk);
        chk("fail_cnt_2", fail_cnt, 2);
        count_err(n);
        chk("fail2_len", n, 10000);
        enter4(4'd1, 4'd2, 4'd3, 4'd5);
        @(negedge clk);
        chk("fail_cnt_3", fail_cnt, 3);
        count_err(n);
        chk("fail3_len", n, 10000);
        chk("lockout_start", locked_out, 1);
        n = 0;
        while (locked_out && n < 40000) begin
            n++;
            if (n >= 100 && n < 108) begin
                if (n % 2 == 0) begin
                    enc = 4'((n - 100) / 2 + 1);
                    pb  = 3'b001;
                end else begin
                    pb  = 3'b000;
                end
            end else if (n == 200) pb = 3'b010;
            else if (n == 300) pb = 3'b100;
            else pb = 3'b000;
            @(negedge clk);
        end
        pb = 3'b000;
        chk("lockout_len", n, 30000);
        chk("lockout_fail_cnt", fail_cnt, 0);
        chk("lockout_unl", unlocked, 0);
        chk("lockout_sel", disp_sel, 0);
        enter4(4'd1, 4'd2, 4'd3, 4'd4);
        @(negedge clk);
        chk("post_lock_unlock", unlocked, 1);
        press(3'b010, 4'd0);

        // async reset in the middle of FAIL
        enter4(4'd1, 4'd2, 4'd3, 4'd5);
        @(negedge clk);
        chk("rst_fail_err", err, 1);
        repeat (5000) @(negedge clk);
        #2 rstn = 1'b0;
        #1;
        chk("async_err", err, 0);
        chk("async_fail_cnt", fail_cnt, 0);
        chk("async_unl", unlocked, 0);
        chk("async_lock", locked_out, 0);
        @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
        chk("post_rst_err", err, 0);
        enter4(4'd1, 4'd2, 4'd3, 4'd4);
        @(negedge clk);
        chk("post_rst_unlock", unlocked, 1);

`ifdef CODE_LOCK_PROGRAM_EN
        press(3'b100, 4'd0);
        chk("prog_enter", unlocked, 0);
        press(3'b001, 4'd9);
        chk("prog_sel1", disp_sel, 1);
        press(3'b001, 4'd8);
        press(3'b001, 4'd7);
        press(3'b001, 4'd6);
        chk("prog_back_open", unlocked, 1);
        press(3'b100, 4'd0);
        press(3'b001, 4'd5);
        press(3'b010, 4'd0);
        chk("prog_abort_open", unlocked, 1);
        press(3'b010, 4'd0);
        chk("prog_relock", unlocked, 0);
        enter4(4'd1, 4'd2, 4'd3, 4'd4);
        @(negedge clk);
        chk("old_code_fails", err, 1);
        count_err(n);
        chk("prog_fail_len", n, 10000);
        enter4(4'd9, 4'd8, 4'd7, 4'd6);
        @(negedge clk);
        chk("new_code_unlocks", unlocked, 1);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
